// File: rtl/kcode_enc_pipe.sv
// kcode_enc_pipe: registered multi-lane 8b/10b K-character encoder.
// Each lane encodes one of the 12 legal K-codes using its running disparity
// (RD) and updates that RD. Illegal bytes produce codeword 0 and set out_err.
// An illegal byte leaves the RD unchanged.
// Valid/ready flow control gives 1-cycle latency and 1 beat/clk throughput.
//
// Optional feature: define KCODE_ERR_CNT_EN to enable the saturating illegal-byte
// counter on err_cnt. With the macro undefined, err_cnt is tied to 0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready is combinational)
//   in_data   [8*LANES]     K-code bytes, lane i = [8i+7:8i]
//   out_valid/out_ready     output handshake
//   out_data  [10*LANES]    codewords, lane i = [10i+9:10i], bit 9 = a
//   out_err   [LANES]       per-lane illegal-byte flag
//   rd_state  [LANES]       current RD per lane (1 = RD+)
//   err_cnt   [ERR_CNT_W]   saturating illegal-byte count
module kcode_enc_pipe #(
    parameter int unsigned LANES     = 1,
    parameter int unsigned CHAIN     = 0,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_err,
    output logic [LANES-1:0]      rd_state,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned DW = 10 * LANES;

    // RD- codeword lookup; bit 10 marks a legal K-code.
    function automatic logic [10:0] kcode_lookup(input logic [7:0] b);
        case (b)
            8'h1C:   return {1'b1, 10'b0011110100};
            8'h3C:   return {1'b1, 10'b0011111001};
            8'h5C:   return {1'b1, 10'b0011110101};
            8'h7C:   return {1'b1, 10'b0011110011};
            8'h9C:   return {1'b1, 10'b0011110010};
            8'hBC:   return {1'b1, 10'b0011111010};
            8'hDC:   return {1'b1, 10'b0011110110};
            8'hFC:   return {1'b1, 10'b0011111000};
            8'hF7:   return {1'b1, 10'b1110101000};
            8'hFB:   return {1'b1, 10'b1101101000};
            8'hFD:   return {1'b1, 10'b1011101000};
            8'hFE:   return {1'b1, 10'b0111101000};
            default: return 11'h000;
        endcase
    endfunction

    logic [DW-1:0]     out_data_q, out_data_d;
    logic [LANES-1:0]  out_err_q,  out_err_d;
    logic              out_valid_q, out_valid_d;
    logic [LANES-1:0]  rd_q, rd_d;

    logic [DW-1:0]     enc_data;
    logic [LANES-1:0]  enc_err;
    logic [LANES-1:0]  enc_rd;
    logic              chain_rd;
    logic              lane_rd;
    logic              lane_post;
    logic [10:0]       lut;
    logic [9:0]        lane_cw;
    logic              accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Per-lane encode. In chained mode the RD ripples lane 0 -> LANES-1 in one cycle.
    always_comb begin
        enc_data  = '0;
        enc_err   = '0;
        enc_rd    = rd_q;
        chain_rd  = rd_q[0];
        lane_rd   = 1'b0;
        lane_post = 1'b0;
        lut       = '0;
        lane_cw   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_rd = (CHAIN != 0) ? chain_rd : rd_q[i];
            lut     = kcode_lookup(in_data[8*i +: 8]);
            if (lut[10]) begin
                lane_cw   = lane_rd ? ~lut[9:0] : lut[9:0];
                // Unbalanced codewords (popcount != 5) flip the disparity.
                lane_post = lane_rd ^ ($countones(lut[9:0]) != 5);
            end else begin
                lane_cw   = 10'h000;
                lane_post = lane_rd;
            end
            enc_data[10*i +: 10] = lane_cw;
            enc_err[i]           = ~lut[10];
            enc_rd[i]            = lane_post;
            chain_rd             = lane_post;
        end
        if (CHAIN != 0) begin
            enc_rd = {LANES{chain_rd}};
        end
    end

    // Output register / RD next state: load on accept, clear valid on drain.
    always_comb begin
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        if (accept) begin
            out_data_d  = enc_data;
            out_err_d   = enc_err;
            out_valid_d = 1'b1;
            rd_d        = enc_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign rd_state  = rd_q;

`ifdef KCODE_ERR_CNT_EN
    // Sum is 4 bits wider than the counter so one beat (<= 8 errors) cannot wrap.
    localparam int unsigned SUM_W = ERR_CNT_W + 4;

    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]     err_sum;

    always_comb begin
        err_sum   = SUM_W'(err_cnt_q) + SUM_W'($countones(enc_err));
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (err_sum[SUM_W-1:ERR_CNT_W] != '0) begin
                err_cnt_d = '1;
            end else begin
                err_cnt_d = err_sum[ERR_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_kcode_enc_pipe.sv
// tb_kcode_enc_pipe: directed, table-driven bench for kcode_enc_pipe.
// Three instances: LANES=1, LANES=4 chained, LANES=4 independent.
module tb_kcode_enc_pipe;

    logic clk;
    logic rst_n;

    // LANES=1 instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data;
    logic [9:0]  a_out_data;
    logic [0:0]  a_out_err, a_rd;
    logic [15:0] a_err_cnt;

    // LANES=4 CHAIN=1 instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data;
    logic [39:0] c_out_data;
    logic [3:0]  c_out_err, c_rd;
    logic [15:0] c_err_cnt;

    // LANES=4 CHAIN=0 instance
    logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [31:0] p_in_data;
    logic [39:0] p_out_data;
    logic [3:0]  p_out_err, p_rd;
    logic [15:0] p_err_cnt;

    kcode_enc_pipe #(.LANES(1), .CHAIN(0), .ERR_CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err(a_out_err), .rd_state(a_rd), .err_cnt(a_err_cnt)
    );

    kcode_enc_pipe #(.LANES(4), .CHAIN(1), .ERR_CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_err(c_out_err), .rd_state(c_rd), .err_cnt(c_err_cnt)
    );

    kcode_enc_pipe #(.LANES(4), .CHAIN(0), .ERR_CNT_W(16)) u_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .out_err(p_out_err), .rd_state(p_rd), .err_cnt(p_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [9:0] cw;
        logic       err;
        logic       rd;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

`ifdef KCODE_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    initial begin
        // Single-lane stream starting from RD-; rd is the RD after the symbol.
        tbl[0]  = '{8'hBC, 10'b0011111010, 1'b0, 1'b1};
        tbl[1]  = '{8'hBC, 10'b1100000101, 1'b0, 1'b0};
        tbl[2]  = '{8'h1C, 10'b0011110100, 1'b0, 1'b0};
        tbl[3]  = '{8'h1C, 10'b0011110100, 1'b0, 1'b0};
        tbl[4]  = '{8'h3C, 10'b0011111001, 1'b0, 1'b1};
        tbl[5]  = '{8'h1C, 10'b1100001011, 1'b0, 1'b1};
        tbl[6]  = '{8'hF7, 10'b0001010111, 1'b0, 1'b1};
        tbl[7]  = '{8'h00, 10'b0000000000, 1'b1, 1'b1};
        tbl[8]  = '{8'h7C, 10'b1100001100, 1'b0, 1'b0};
        tbl[9]  = '{8'hFE, 10'b0111101000, 1'b0, 1'b0};
        tbl[10] = '{8'h5C, 10'b0011110101, 1'b0, 1'b1};
        tbl[11] = '{8'hDC, 10'b1100001001, 1'b0, 1'b0};
        tbl[12] = '{8'h9C, 10'b0011110010, 1'b0, 1'b0};
        tbl[13] = '{8'hFC, 10'b0011111000, 1'b0, 1'b0};
        tbl[14] = '{8'hFB, 10'b1101101000, 1'b0, 1'b0};
        tbl[15] = '{8'h1D, 10'b0000000000, 1'b1, 1'b0};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
        p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_rd",        64'(a_rd),        64'd0);
        chk("rst_err_cnt",   64'(a_err_cnt),   64'd0);
        chk("rst_c_data",    64'(c_out_data),  64'd0);
        chk("rst_p_err",     64'(p_out_err),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);

        // Table-driven single-lane stream, one beat per clock
        a_in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            a_in_data = tbl[i].din;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("v%0d_cw", i),    64'(a_out_data),  64'(tbl[i].cw));
            chk($sformatf("v%0d_err", i),   64'(a_out_err),   64'(tbl[i].err));
            chk($sformatf("v%0d_rd", i),    64'(a_rd),        64'(tbl[i].rd));
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 64'(a_out_valid), 64'd0);
        chk("idle_rd",     64'(a_rd),        64'd0);
        chk("tbl_err_cnt", 64'(a_err_cnt),   CNT_EN ? 64'd2 : 64'd0);

        // Chained lanes: BC x4 alternates RD across lanes
        c_in_valid = 1'b1;
        c_in_data  = {8'hBC, 8'hBC, 8'hBC, 8'hBC};
        @(negedge clk);
        chk("chain1_data", 64'(c_out_data),
            64'({10'b1100000101, 10'b0011111010, 10'b1100000101, 10'b0011111010}));
        chk("chain1_rd",   64'(c_rd), 64'b0000);
        // Lane 1 illegal: RD passes through to lane 2
        c_in_data  = {8'h1C, 8'h3C, 8'h00, 8'hBC};
        @(negedge clk);
        chk("chain2_data", 64'(c_out_data),
            64'({10'b0011110100, 10'b1100000110, 10'b0000000000, 10'b0011111010}));
        chk("chain2_err",  64'(c_out_err), 64'b0010);
        chk("chain2_rd",   64'(c_rd), 64'b0000);
        // Last lane flips: stored RD becomes RD+ for all bits
        c_in_data  = {8'hBC, 8'h1C, 8'h1C, 8'h1C};
        @(negedge clk);
        chk("chain3_data", 64'(c_out_data),
            64'({10'b0011111010, 10'b0011110100, 10'b0011110100, 10'b0011110100}));
        chk("chain3_rd",   64'(c_rd), 64'b1111);
        // Lane 0 of the next beat starts from the stored RD+
        c_in_data  = {8'h1C, 8'h1C, 8'h1C, 8'h1C};
        @(negedge clk);
        chk("chain4_data", 64'(c_out_data),
            64'({10'b1100001011, 10'b1100001011, 10'b1100001011, 10'b1100001011}));
        chk("chain4_rd",   64'(c_rd), 64'b1111);
        c_in_valid = 1'b0;

        // Independent lanes with an illegal lane 3
        p_in_valid = 1'b1;
        p_in_data  = {8'h00, 8'h3C, 8'h3C, 8'h3C};
        @(negedge clk);
        chk("par1_data", 64'(p_out_data),
            64'({10'b0000000000, 10'b0011111001, 10'b0011111001, 10'b0011111001}));
        chk("par1_err",  64'(p_out_err), 64'b1000);
        chk("par1_rd",   64'(p_rd),      64'b0111);
        chk("par1_cnt",  64'(p_err_cnt), CNT_EN ? 64'd1 : 64'd0);
        p_in_data  = {8'hBC, 8'h1C, 8'hFF, 8'h3C};
        @(negedge clk);
        chk("par2_data", 64'(p_out_data),
            64'({10'b0011111010, 10'b1100001011, 10'b0000000000, 10'b1100000110}));
        chk("par2_err",  64'(p_out_err), 64'b0010);
        chk("par2_rd",   64'(p_rd),      64'b1110);
        chk("par2_cnt",  64'(p_err_cnt), CNT_EN ? 64'd2 : 64'd0);
        p_in_valid = 1'b0;

        // Backpressure: accept BC, then stall 3 cycles with 1C pending
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'hBC;
        @(negedge clk);
        a_in_data   = 8'h1C;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d_ready", s), 64'(a_in_ready),  64'd0);
            chk($sformatf("stall%0d_valid", s), 64'(a_out_valid), 64'd1);
            chk($sformatf("stall%0d_data", s),  64'(a_out_data),  64'(10'b0011111010));
            chk($sformatf("stall%0d_rd", s),    64'(a_rd),        64'd1);
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        chk("rel1_data", 64'(a_out_data), 64'(10'b1100001011));
        chk("rel1_rd",   64'(a_rd),       64'd1);
        a_in_data = 8'hBC;
        @(negedge clk);
        chk("rel2_data", 64'(a_out_data), 64'(10'b1100000101));
        chk("rel2_rd",   64'(a_rd),       64'd0);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("rel_drain", 64'(a_out_valid), 64'd0);

        // Reset mid-burst after three K28.5
        a_in_valid = 1'b1;
        a_in_data  = 8'hBC;
        repeat (3) @(negedge clk);
        chk("pre_rst_rd",    64'(a_rd),        64'd1);
        chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_rd",    64'(a_rd),        64'd0);
        chk("mid_rst_data",  64'(a_out_data),  64'd0);
        @(negedge clk);
        chk("mid_rst_cnt",   64'(a_err_cnt),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_data", 64'(a_out_data), 64'(10'b0011111010));
        chk("post_rst_rd",   64'(a_rd),       64'd1);
        a_in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
